csr_trap_sequencer: RTL and testbench
=====================================

// Module: csr_trap_sequencer
// PURPOSE
//   Multi-cycle controller that owns the machine-mode CSR write port during traps and MRET.
//   Arbitrates F/D-stage and E/M-stage exception reports and MRET requests, then writes
//   mepc/mcause/mtval/mstatus one per cycle. It stalls and flushes the pipeline, redirects
//   the PC, and updates privilege. Sits beside the CSR unit; its write port is muxed ahead of
//   the W-stage CSR write.
// PARAMETERS
//   XLEN    `XLEN_64b  width code; data width W = 1<<(XLEN+4) (32b or 64b)
// PORTS
//   i_clk              in   1   clock
//   i_rst              in   1   asynchronous reset, active-low
//   i_clk_en           in   1   global clock enable; state and outputs freeze when low
//   i_exc_valid_fd     in   1   F/D-stage exception valid
//   i_exc_code_fd      in   4   F/D exception code
//   i_exc_pc_fd        in   W   F/D faulting PC
//   i_exc_valid_em     in   1   E/M-stage exception valid
//   i_exc_code_em      in   4   E/M exception code
//   i_exc_pc_em        in   W   E/M faulting PC
//   i_exc_addr_em      in   W   E/M faulting data address
//   i_mret             in   1   MRET at E stage
//   i_wb_csr_we        in   1   W-stage CSR write in flight
//   i_mstatus          in   W   current mstatus
//   i_mtvec            in   W   current mtvec
//   i_mepc             in   W   current mepc
//   i_current_priv     in   2   current privilege (00 U, 11 M)
//   o_csr_we           out  1   sequencer CSR write enable
//   o_csr_addr         out  12  CSR write address
//   o_csr_wdata        out  W   CSR write data
//   o_stall            out  1   stall all pipeline stages
//   o_flush            out  1   flush F/D, D/E, E/M registers
//   o_redirect         out  1   one-cycle PC redirect pulse
//   o_redirect_pc      out  W   redirect target
//   o_priv_we          out  1   privilege update strobe
//   o_new_priv         out  2   new privilege
//   o_busy             out  1   FSM not in IDLE
//   o_disable_exc_1cc  out  1   masks exception inputs the cycle after redirect
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; captured code/PC/tval registers cleared.
//   Priority in IDLE: em exception > fd exception > mret. Losers are dropped; they are flushed.
//   Inputs are ignored outside IDLE and while o_disable_exc_1cc=1.
//   States: IDLE, DRAIN, T_EPC, T_CAUSE, T_TVAL, T_STATUS, M_STATUS, REDIR, MASK.
//   IDLE + event: capture cause/pc/tval and trap-or-mret. Next state is DRAIN if i_wb_csr_we,
//     else T_EPC (trap) or M_STATUS (mret).
//   DRAIN: hold until i_wb_csr_we=0, then go to T_EPC or M_STATUS.
//   T_EPC: we=1, addr 0x341, data = pc with bits[1:0] forced to 0.
//   T_CAUSE: we=1, addr 0x342, data = zero-extended 4-bit code (interrupt bit 0).
//   T_TVAL: we=1, addr 0x343. Data = addr_em for codes 4-7, pc for codes 0/1, else 0.
//   T_STATUS: we=1, addr 0x300. MPIE<=MIE, MIE<=0, MPP<=i_current_priv; other bits unchanged.
//     o_priv_we=1, o_new_priv=11.
//   M_STATUS: we=1, addr 0x300. MIE<=MPIE, MPIE<=1, MPP<=00.
//     o_priv_we=1, o_new_priv = old MPP.
//   REDIR: o_redirect=1, target {mtvec[W-1:2],2'b00} for a trap (vectored mode unused for
//     exceptions) or i_mepc for mret. Next state MASK.
//   MASK: o_disable_exc_1cc=1 for one cycle, then IDLE.
//   o_stall = o_busy = (state!=IDLE). o_flush=1 in DRAIN through REDIR. o_csr_we=0 in
//     IDLE, DRAIN, REDIR and MASK.
//   Latency, event to redirect with no drain: trap 5 enabled cycles, mret 2.
//   mstatus writes use i_mstatus sampled in the write state, after any drained W write.
//   Every state advances only on i_clk_en=1; reset mid-sequence aborts to IDLE.
// TESTING
//   em code 5, pc 0x100, addr 0x2003, mtvec 0x800, priv U -> writes mepc=0x100, mcause=5,
//     mtval=0x2003, mstatus MPP=00; redirect 0x800; priv 11.
//   fd code 2 and em code 4 in the same cycle -> only em is serviced, mcause=4.
//   mret with mstatus MPP=00, MPIE=1, mepc=0x240 -> MIE=1, MPP=00, priv 00; redirect 0x240
//     2 cycles later.
//   i_wb_csr_we held 3 cycles at the event -> 3 cycles in DRAIN, then normal order; no
//     overlapping write enables.
//   i_clk_en low for 2 cycles mid-trap -> outputs held; sequence resumes unchanged.
//   i_rst asserted low in T_TVAL -> all outputs 0 at once; IDLE after release.

Source files
------------

// File: rtl/csr_trap_sequencer_if.sv
// Trap/MRET sequencer bundle: pipeline exception reports and CSR snapshots in, CSR write port,
// pipeline control, redirect and privilege update out.
interface csr_trap_sequencer_if #(
  parameter int XLEN = 2
);
  localparam int W = 1 << (XLEN + 4);

  logic         i_exc_valid_fd;
  logic [3:0]   i_exc_code_fd;
  logic [W-1:0] i_exc_pc_fd;
  logic         i_exc_valid_em;
  logic [3:0]   i_exc_code_em;
  logic [W-1:0] i_exc_pc_em;
  logic [W-1:0] i_exc_addr_em;
  logic         i_mret;
  logic         i_wb_csr_we;
  logic [W-1:0] i_mstatus;
  logic [W-1:0] i_mtvec;
  logic [W-1:0] i_mepc;
  logic [1:0]   i_current_priv;

  logic         o_csr_we;
  logic [11:0]  o_csr_addr;
  logic [W-1:0] o_csr_wdata;
  logic         o_stall;
  logic         o_flush;
  logic         o_redirect;
  logic [W-1:0] o_redirect_pc;
  logic         o_priv_we;
  logic [1:0]   o_new_priv;
  logic         o_busy;
  logic         o_disable_exc_1cc;

  modport master (
    input  i_exc_valid_fd, i_exc_code_fd, i_exc_pc_fd,
    input  i_exc_valid_em, i_exc_code_em, i_exc_pc_em, i_exc_addr_em,
    input  i_mret, i_wb_csr_we, i_mstatus, i_mtvec, i_mepc, i_current_priv,
    output o_csr_we, o_csr_addr, o_csr_wdata, o_stall, o_flush,
    output o_redirect, o_redirect_pc, o_priv_we, o_new_priv, o_busy, o_disable_exc_1cc
  );

  modport slave (
    output i_exc_valid_fd, i_exc_code_fd, i_exc_pc_fd,
    output i_exc_valid_em, i_exc_code_em, i_exc_pc_em, i_exc_addr_em,
    output i_mret, i_wb_csr_we, i_mstatus, i_mtvec, i_mepc, i_current_priv,
    input  o_csr_we, o_csr_addr, o_csr_wdata, o_stall, o_flush,
    input  o_redirect, o_redirect_pc, o_priv_we, o_new_priv, o_busy, o_disable_exc_1cc
  );
endinterface

// File: rtl/csr_trap_sequencer.sv
// Owns the machine-mode CSR write port during traps and MRET: writes mepc/mcause/mtval/mstatus
// one per cycle, stalls and flushes the pipeline, redirects the PC and updates privilege.
module csr_trap_sequencer #(
  parameter int XLEN = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clk_en,
  csr_trap_sequencer_if.master  bus
);
  localparam int W = 1 << (XLEN + 4);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LSB  = 11;

  typedef enum logic [3:0] {
    IDLE, DRAIN, T_EPC, T_CAUSE, T_TVAL, T_STATUS, M_STATUS, REDIR, MASK
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   cap_code;
  logic [W-1:0] cap_pc;
  logic [W-1:0] cap_tval;
  logic         cap_trap;

  // Event arbitration in IDLE: E/M exception beats F/D exception beats MRET.
  logic         take_em, take_fd, take_mret, take_evt;
  logic [3:0]   sel_code;
  logic [W-1:0] sel_pc;
  logic [W-1:0] sel_tval;

  always_comb begin
    take_em   = bus.i_exc_valid_em;
    take_fd   = !bus.i_exc_valid_em && bus.i_exc_valid_fd;
    take_mret = !bus.i_exc_valid_em && !bus.i_exc_valid_fd && bus.i_mret;
    take_evt  = take_em || take_fd || take_mret;
    sel_code  = take_em ? bus.i_exc_code_em : (take_fd ? bus.i_exc_code_fd : 4'd0);
    sel_pc    = take_em ? bus.i_exc_pc_em   : (take_fd ? bus.i_exc_pc_fd   : '0);
    if (take_mret)
      sel_tval = '0;
    else if (sel_code inside {4'd0, 4'd1})
      sel_tval = sel_pc;
    else if (sel_code inside {[4'd4:4'd7]})
      sel_tval = bus.i_exc_addr_em;
    else
      sel_tval = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      cap_code <= '0;
      cap_pc   <= '0;
      cap_tval <= '0;
      cap_trap <= 1'b0;
    end else if (i_clk_en) begin
      state <= state_nxt;
      if (state == IDLE && take_evt) begin
        cap_code <= sel_code;
        cap_pc   <= sel_pc;
        cap_tval <= sel_tval;
        cap_trap <= !take_mret;
      end
    end
  end

  logic         csr_we;
  logic [11:0]  csr_addr;
  logic [W-1:0] csr_wdata;
  logic         flush, redirect, priv_we, disable_exc;
  logic [W-1:0] redirect_pc;
  logic [1:0]   new_priv;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    csr_we      = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    priv_we     = 1'b0;
    new_priv    = 2'b00;
    disable_exc = 1'b0;
    unique case (state)
      IDLE: begin
        if (take_evt)
          state_nxt = bus.i_wb_csr_we ? DRAIN : (take_mret ? M_STATUS : T_EPC);
      end
      DRAIN: begin
        flush = 1'b1;
        if (!bus.i_wb_csr_we)
          state_nxt = cap_trap ? T_EPC : M_STATUS;
      end
      T_EPC: begin
        flush     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = {cap_pc[W-1:2], 2'b00};
        state_nxt = T_CAUSE;
      end
      T_CAUSE: begin
        flush     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = {{(W-4){1'b0}}, cap_code};
        state_nxt = T_TVAL;
      end
      T_TVAL: begin
        flush     = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = CSR_MTVAL;
        csr_wdata = cap_tval;
        state_nxt = T_STATUS;
      end
      T_STATUS: begin
        flush                           = 1'b1;
        csr_we                          = 1'b1;
        csr_addr                        = CSR_MSTATUS;
        csr_wdata                       = bus.i_mstatus;
        csr_wdata[MPIE_BIT]             = bus.i_mstatus[MIE_BIT];
        csr_wdata[MIE_BIT]              = 1'b0;
        csr_wdata[MPP_LSB+1:MPP_LSB]    = bus.i_current_priv;
        priv_we                         = 1'b1;
        new_priv                        = 2'b11;
        state_nxt                       = REDIR;
      end
      M_STATUS: begin
        flush                           = 1'b1;
        csr_we                          = 1'b1;
        csr_addr                        = CSR_MSTATUS;
        csr_wdata                       = bus.i_mstatus;
        csr_wdata[MIE_BIT]              = bus.i_mstatus[MPIE_BIT];
        csr_wdata[MPIE_BIT]             = 1'b1;
        csr_wdata[MPP_LSB+1:MPP_LSB]    = 2'b00;
        priv_we                         = 1'b1;
        new_priv                        = bus.i_mstatus[MPP_LSB+1:MPP_LSB];
        state_nxt                       = REDIR;
      end
      REDIR: begin
        flush       = 1'b1;
        redirect    = 1'b1;
        // Exceptions always go to the mtvec base; vectored mode only matters for interrupts.
        redirect_pc = cap_trap ? {bus.i_mtvec[W-1:2], 2'b00} : bus.i_mepc;
        state_nxt   = MASK;
      end
      MASK: begin
        disable_exc = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^bus.i_mtvec[1:0];

  assign bus.o_csr_we          = csr_we;
  assign bus.o_csr_addr        = csr_addr;
  assign bus.o_csr_wdata       = csr_wdata;
  assign bus.o_stall           = (state != IDLE);
  assign bus.o_busy            = (state != IDLE);
  assign bus.o_flush           = flush;
  assign bus.o_redirect        = redirect;
  assign bus.o_redirect_pc     = redirect_pc;
  assign bus.o_priv_we         = priv_we;
  assign bus.o_new_priv        = new_priv;
  assign bus.o_disable_exc_1cc = disable_exc;
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: trap and MRET sequences, arbitration, drain,
// clock-enable freeze and mid-sequence reset, checked with immediate assertions.
module tb_csr_trap_sequencer;
  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  logic i_clk_en = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  csr_trap_sequencer_if #(.XLEN(2)) bus ();

  csr_trap_sequencer #(.XLEN(2)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clk_en (i_clk_en),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Packs the CSR write port and the control flags for compact comparisons.
  function automatic logic [127:0] wr_port();
    return {51'b0, bus.o_csr_we, bus.o_csr_addr, bus.o_csr_wdata};
  endfunction

  function automatic logic [127:0] flags();
    return {121'b0, bus.o_busy, bus.o_stall, bus.o_flush, bus.o_csr_we,
            bus.o_redirect, bus.o_priv_we, bus.o_disable_exc_1cc};
  endfunction

  function automatic logic [127:0] wr(input logic [11:0] addr, input logic [63:0] data);
    return {51'b0, 1'b1, addr, data};
  endfunction

  initial begin
    bus.i_exc_valid_fd = 1'b0; bus.i_exc_code_fd = '0; bus.i_exc_pc_fd = '0;
    bus.i_exc_valid_em = 1'b0; bus.i_exc_code_em = '0; bus.i_exc_pc_em = '0;
    bus.i_exc_addr_em  = '0;   bus.i_mret = 1'b0;      bus.i_wb_csr_we = 1'b0;
    bus.i_mstatus = '0; bus.i_mtvec = '0; bus.i_mepc = '0; bus.i_current_priv = 2'b00;

    // Reset state
    #2;
    check("reset_flags", flags(), 0);
    check("reset_wport", wr_port(), 0);
    check("reset_redir_pc", {bus.o_redirect_pc, bus.o_new_priv}, 0);
    @(negedge i_clk);
    i_rst = 1'b1;

    // Trap: em code 5 from U mode
    bus.i_exc_valid_em = 1'b1; bus.i_exc_code_em = 4'd5;
    bus.i_exc_pc_em = 64'h100; bus.i_exc_addr_em = 64'h2003;
    bus.i_mtvec = 64'h800; bus.i_mstatus = 64'h8; bus.i_current_priv = 2'b00;
    step(); bus.i_exc_valid_em = 1'b0;
    check("t1_epc", wr_port(), wr(12'h341, 64'h100));
    check("t1_epc_flags", flags(), 7'b1111000);
    step(); check("t1_cause", wr_port(), wr(12'h342, 64'd5));
    step(); check("t1_tval", wr_port(), wr(12'h343, 64'h2003));
    step(); check("t1_status", wr_port(), wr(12'h300, 64'h80));
    check("t1_priv", {bus.o_priv_we, bus.o_new_priv}, 3'b111);
    step(); check("t1_redir", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 64'h800});
    check("t1_redir_flags", flags(), 7'b1110100);
    step(); check("t1_mask_flags", flags(), 7'b1100001);
    step(); check("t1_idle_flags", flags(), 0);

    // fd, em and mret together: only em is serviced
    bus.i_exc_valid_fd = 1'b1; bus.i_exc_code_fd = 4'd2; bus.i_exc_pc_fd = 64'h400;
    bus.i_exc_valid_em = 1'b1; bus.i_exc_code_em = 4'd4; bus.i_exc_pc_em = 64'h102;
    bus.i_exc_addr_em = 64'h3000; bus.i_mret = 1'b1;
    bus.i_mtvec = 64'h803; bus.i_current_priv = 2'b11; bus.i_mstatus = 64'h88;
    step(); bus.i_exc_valid_fd = 1'b0; bus.i_exc_valid_em = 1'b0; bus.i_mret = 1'b0;
    check("t2_epc_align", wr_port(), wr(12'h341, 64'h100));
    step(); check("t2_cause", wr_port(), wr(12'h342, 64'd4));
    step(); check("t2_tval", wr_port(), wr(12'h343, 64'h3000));
    step(); check("t2_status", wr_port(), wr(12'h300, 64'h1880));
    check("t2_priv", {bus.o_priv_we, bus.o_new_priv}, 3'b111);
    step(); check("t2_redir", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 64'h800});
    bus.i_exc_valid_fd = 1'b1; bus.i_exc_code_fd = 4'd3;
    step(); check("t2_mask", flags(), 7'b1100001);
    step(); check("t2_ignored_in_mask", flags(), 0);
    bus.i_exc_valid_fd = 1'b0;
    step(); check("t2_still_idle", flags(), 0);

    // MRET back to U mode
    bus.i_mstatus = 64'h80; bus.i_mepc = 64'h240; bus.i_mret = 1'b1;
    step(); bus.i_mret = 1'b0;
    check("t3_mstatus", wr_port(), wr(12'h300, 64'h88));
    check("t3_priv", {bus.o_priv_we, bus.o_new_priv}, 3'b100);
    check("t3_no_redir_yet", bus.o_redirect, 1'b0);
    step(); check("t3_redir", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 64'h240});
    step(); step(); check("t3_idle", flags(), 0);

    // MRET back to M mode
    bus.i_mstatus = 64'h1808; bus.i_mret = 1'b1;
    step(); bus.i_mret = 1'b0;
    check("t3b_mstatus", wr_port(), wr(12'h300, 64'h80));
    check("t3b_priv", {bus.o_priv_we, bus.o_new_priv}, 3'b111);
    step(); step(); step(); check("t3b_idle", flags(), 0);

    // Drain: W-stage CSR write in flight for 3 cycles at the event
    bus.i_exc_valid_em = 1'b1; bus.i_exc_code_em = 4'd1; bus.i_exc_pc_em = 64'h503;
    bus.i_wb_csr_we = 1'b1; bus.i_mtvec = 64'h800;
    step(); bus.i_exc_valid_em = 1'b0;
    check("t4_drain1", flags(), 7'b1110000);
    step(); check("t4_drain2", flags(), 7'b1110000);
    step(); check("t4_drain3", flags(), 7'b1110000);
    bus.i_wb_csr_we = 1'b0;
    step(); check("t4_epc", wr_port(), wr(12'h341, 64'h500));
    step(); check("t4_cause", wr_port(), wr(12'h342, 64'd1));
    step(); check("t4_tval_pc", wr_port(), wr(12'h343, 64'h503));
    step(); step(); check("t4_redir", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 64'h800});
    step(); step(); check("t4_idle", flags(), 0);

    // Clock enable low for 2 cycles in T_CAUSE
    bus.i_exc_valid_em = 1'b1; bus.i_exc_code_em = 4'd6; bus.i_exc_pc_em = 64'h600;
    bus.i_exc_addr_em = 64'h7000;
    step(); bus.i_exc_valid_em = 1'b0;
    check("t5_epc", wr_port(), wr(12'h341, 64'h600));
    step(); check("t5_cause", wr_port(), wr(12'h342, 64'd6));
    i_clk_en = 1'b0;
    step(); check("t5_hold1", wr_port(), wr(12'h342, 64'd6));
    step(); check("t5_hold2", wr_port(), wr(12'h342, 64'd6));
    check("t5_hold_flags", flags(), 7'b1111000);
    i_clk_en = 1'b1;
    step(); check("t5_tval", wr_port(), wr(12'h343, 64'h7000));
    step(); check("t5_status_addr", bus.o_csr_addr, 12'h300);
    step(); check("t5_redir", {bus.o_redirect, bus.o_redirect_pc}, {1'b1, 64'h800});
    step(); step(); check("t5_idle", flags(), 0);

    // Reset asserted in T_TVAL
    bus.i_exc_valid_em = 1'b1; bus.i_exc_code_em = 4'd0; bus.i_exc_pc_em = 64'h700;
    step(); bus.i_exc_valid_em = 1'b0;
    step(); step(); check("t6_tval_pc", wr_port(), wr(12'h343, 64'h700));
    i_rst = 1'b0;
    #1;
    check("t6_rst_flags", flags(), 0);
    check("t6_rst_wport", wr_port(), 0);
    step(); check("t6_rst_held", flags(), 0);
    i_rst = 1'b1;
    step(); check("t6_idle_after", flags(), 0);
    check("t6_idle_wport", wr_port(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
